// File: rtl/z_result_fifo_pkg.sv
// Shared defaults for the Z result FIFO: half-width, depth and derived pointer/count widths.
package z_fifo_pkg;

    localparam int Z_W     = 32;
    localparam int Z_DEPTH = 4;
    localparam int PTR_W   = $clog2(Z_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

endpackage

// File: rtl/z_result_fifo_if.sv
// Bus-side signal bundle of the Z result FIFO; the datapath drives (master), the FIFO responds (slave).
interface z_result_fifo_if
    import z_fifo_pkg::*;
#(
    parameter int W     = Z_W,
    parameter int DEPTH = Z_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Handshake: push is taken on a clock edge only when !full or pop is also high;
    // pop is taken only when !empty. Rejected requests raise the sticky overflow/underflow.
    logic              enable;
    logic              Zlow;
    logic              Zhi;
    logic              push;
    logic [2*W-1:0]    input_DZ;
    logic              pop;
    logic              wr_lo;
    logic              wr_hi;
    logic [W-1:0]      bus_in;
    logic [W-1:0]      output_QZ;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              overflow;
    logic              underflow;

    modport master (
        output enable, Zlow, Zhi, push, input_DZ, pop, wr_lo, wr_hi, bus_in,
        input  output_QZ, count, full, empty, overflow, underflow
    );

    modport slave (
        input  enable, Zlow, Zhi, push, input_DZ, pop, wr_lo, wr_hi, bus_in,
        output output_QZ, count, full, empty, overflow, underflow
    );

endinterface

// File: rtl/z_result_fifo_mem.sv
// Entry storage: full-entry write at the tail, combinational head read, per-half writes into the head.
module z_fifo_mem
    import z_fifo_pkg::*;
#(
    parameter int W     = Z_W,
    parameter int DEPTH = Z_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en_i,
    input  logic [PW-1:0]   wr_addr_i,
    input  logic [2*W-1:0]  wr_data_i,
    input  logic [PW-1:0]   hd_addr_i,
    input  logic            hd_wr_lo_i,
    input  logic            hd_wr_hi_i,
    input  logic [W-1:0]    hd_data_i,
    output logic [2*W-1:0]  hd_data_o
);

    logic [2*W-1:0] mem_q [DEPTH];

    // Tail and head addresses only coincide when the FIFO is full, and then a head
    // write is only possible without pop, which also blocks the push.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (hd_wr_lo_i) begin
            mem_q[hd_addr_i][W-1:0] <= hd_data_i;
        end
        if (hd_wr_hi_i) begin
            mem_q[hd_addr_i][2*W-1:W] <= hd_data_i;
        end
    end

    assign hd_data_o = mem_q[hd_addr_i];

endmodule

// File: rtl/z_result_fifo.sv
// Queue of 2W-bit mul/div results drained one W-bit half at a time through a registered output.
module z_result_fifo
    import z_fifo_pkg::*;
#(
    parameter int W     = Z_W,
    parameter int DEPTH = Z_DEPTH
) (
    input  logic          clk,
    input  logic          clr,
    z_result_fifo_if.slave zif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [W-1:0]    qz_q, qz_d;
    logic [2*W-1:0]  head;
    logic            full, empty;
    logic            push_ok, pop_ok, hd_wr_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = zif.push && (!full || zif.pop);
    assign pop_ok   = zif.pop && !empty;
    assign hd_wr_ok = !empty && !zif.pop;

    // Storage writes are held off during reset so reset wins over every input.
    z_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk        (clk),
        .wr_en_i    (push_ok && clr),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (zif.input_DZ),
        .hd_addr_i  (rd_ptr_q),
        .hd_wr_lo_i (hd_wr_ok && zif.wr_lo && clr),
        .hd_wr_hi_i (hd_wr_ok && zif.wr_hi && clr),
        .hd_data_i  (zif.bus_in),
        .hd_data_o  (head)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        qz_d     = qz_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        if (zif.push && full && !zif.pop) begin
            ovf_d = 1'b1;
        end
        if (zif.pop && empty) begin
            unf_d = 1'b1;
        end

        // Output sees the pre-edge head, so a same-cycle half write shows up a cycle later.
        if (zif.enable && zif.Zlow) begin
            qz_d = empty ? '0 : head[W-1:0];
        end else if (zif.enable && zif.Zhi) begin
            qz_d = empty ? '0 : head[2*W-1:W];
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            qz_q     <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            qz_q     <= qz_d;
        end
    end

    assign zif.output_QZ = qz_q;
    assign zif.count     = count_q;
    assign zif.full      = full;
    assign zif.empty     = empty;
    assign zif.overflow  = ovf_q;
    assign zif.underflow = unf_q;

endmodule

// File: tb/tb_z_result_fifo.sv
// Directed table-driven bench for z_result_fifo (W=32, DEPTH=4) plus a fill/drain ordering sequence.
module tb_z_result_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    // control bits: {reset, push, pop, wr_lo, wr_hi, enable, Zlow, Zhi}
    localparam logic [7:0] R  = 8'h80;
    localparam logic [7:0] P  = 8'h40;
    localparam logic [7:0] O  = 8'h20;
    localparam logic [7:0] L  = 8'h10;
    localparam logic [7:0] H  = 8'h08;
    localparam logic [7:0] E  = 8'h04;
    localparam logic [7:0] ZL = 8'h02;
    localparam logic [7:0] ZH = 8'h01;
    // expected flag bits: {full, empty, overflow, underflow}
    localparam logic [3:0] FU = 4'h8;
    localparam logic [3:0] EM = 4'h4;
    localparam logic [3:0] OV = 4'h2;
    localparam logic [3:0] UN = 4'h1;

    typedef struct {
        logic [7:0]    ctl;
        logic [63:0]   din;
        logic [31:0]   bus;
        logic [2:0]    e_cnt;
        logic [3:0]    e_flags;
        logic [31:0]   e_qz;
    } vec_t;

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    z_result_fifo_if #(.W(W), .DEPTH(DEPTH)) zif ();

    z_result_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .clr (clr),
        .zif (zif)
    );

    function automatic vec_t mk(input logic [7:0] ctl, input logic [63:0] din,
                                input logic [31:0] bus, input logic [2:0] cnt,
                                input logic [3:0] flags, input logic [31:0] qz);
        vec_t v;
        v.ctl = ctl; v.din = din; v.bus = bus;
        v.e_cnt = cnt; v.e_flags = flags; v.e_qz = qz;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] ctl, input logic [63:0] din, input logic [31:0] bus);
        clr          = ~ctl[7];
        zif.push     = ctl[6];
        zif.pop      = ctl[5];
        zif.wr_lo    = ctl[4];
        zif.wr_hi    = ctl[3];
        zif.enable   = ctl[2];
        zif.Zlow     = ctl[1];
        zif.Zhi      = ctl[0];
        zif.input_DZ = din;
        zif.bus_in   = bus;
    endtask

    task automatic check_state(input string tag, input logic [2:0] cnt,
                               input logic [3:0] flags, input logic [31:0] qz);
        check({tag, ".count"},     32'(zif.count),     32'(cnt));
        check({tag, ".full"},      32'(zif.full),      32'(flags[3]));
        check({tag, ".empty"},     32'(zif.empty),     32'(flags[2]));
        check({tag, ".overflow"},  32'(zif.overflow),  32'(flags[1]));
        check({tag, ".underflow"}, 32'(zif.underflow), 32'(flags[0]));
        check({tag, ".qz"},        zif.output_QZ,      qz);
    endtask

    initial begin
        logic [63:0] a, f, g, x, e;
        logic [63:0] d;
        a = 64'hAAAA_0001_BBBB_0002;
        f = 64'h3333_4444_5555_6666;
        g = 64'h7777_8888_9999_AAAA;
        x = 64'hFFFF_EEEE_DDDD_CCCC;

        // push/read halves, then empty read returns 0
        vecs.push_back(mk(P,      a, 0, 1, 0,  32'h0));
        vecs.push_back(mk(E|ZL,   0, 0, 1, 0,  32'hBBBB_0002));
        vecs.push_back(mk(E|ZH,   0, 0, 1, 0,  32'hAAAA_0001));
        vecs.push_back(mk(O,      0, 0, 0, EM, 32'hAAAA_0001));
        vecs.push_back(mk(E|ZL,   0, 0, 0, EM, 32'h0));
        // fill to full, overflow, push+pop when full with pointer wrap, drain in order
        for (int i = 1; i <= 4; i++) begin
            e = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
            vecs.push_back(mk(P, e, 0, 3'(i), (i == 4) ? FU : 4'h0, 32'h0));
        end
        e = 64'h1000_0005_2000_0005;
        vecs.push_back(mk(P,      e, 0, 4, FU|OV, 32'h0));
        vecs.push_back(mk(P|O,    e, 0, 4, FU|OV, 32'h0));
        vecs.push_back(mk(E|ZL,   0, 0, 4, FU|OV, 32'h2000_0002));
        vecs.push_back(mk(O,      0, 0, 3, OV,    32'h2000_0002));
        vecs.push_back(mk(E|ZH,   0, 0, 3, OV,    32'h1000_0003));
        vecs.push_back(mk(O,      0, 0, 2, OV,    32'h1000_0003));
        vecs.push_back(mk(E|ZL,   0, 0, 2, OV,    32'h2000_0004));
        vecs.push_back(mk(O,      0, 0, 1, OV,    32'h2000_0004));
        vecs.push_back(mk(E|ZH,   0, 0, 1, OV,    32'h1000_0005));
        vecs.push_back(mk(O,      0, 0, 0, EM|OV, 32'h1000_0005));
        // underflow, then push+pop on empty
        vecs.push_back(mk(O,      0, 0, 0, EM|OV|UN, 32'h1000_0005));
        vecs.push_back(mk(P|O,    f, 0, 1, OV|UN,    32'h1000_0005));
        vecs.push_back(mk(E|ZL,   0, 0, 1, OV|UN,    32'h5555_6666));
        // head half overwrite: same-cycle read sees old value
        vecs.push_back(mk(H|E|ZH, 0, 32'hDEAD_BEEF, 1, OV|UN, 32'h3333_4444));
        vecs.push_back(mk(E|ZH,   0, 0, 1, OV|UN, 32'hDEAD_BEEF));
        vecs.push_back(mk(E|ZL,   0, 0, 1, OV|UN, 32'h5555_6666));
        vecs.push_back(mk(P,      g, 0, 2, OV|UN, 32'h5555_6666));
        vecs.push_back(mk(L|O,    0, 32'hCAFE_F00D, 1, OV|UN, 32'h5555_6666));
        vecs.push_back(mk(E|ZH,   0, 0, 1, OV|UN, 32'h7777_8888));
        vecs.push_back(mk(E|ZL,   0, 0, 1, OV|UN, 32'h9999_AAAA));
        // Zlow priority, enable=0 holds, double half write
        vecs.push_back(mk(E|ZH,   0, 0, 1, OV|UN, 32'h7777_8888));
        vecs.push_back(mk(E|ZL|ZH,0, 0, 1, OV|UN, 32'h9999_AAAA));
        vecs.push_back(mk(ZH,     0, 0, 1, OV|UN, 32'h9999_AAAA));
        vecs.push_back(mk(L|H,    0, 32'h1234_5678, 1, OV|UN, 32'h9999_AAAA));
        vecs.push_back(mk(E|ZH,   0, 0, 1, OV|UN, 32'h1234_5678));
        vecs.push_back(mk(E|ZL,   0, 0, 1, OV|UN, 32'h1234_5678));
        // reset mid-traffic wins over push/select
        vecs.push_back(mk(R|P|E|ZL, x, 0, 0, EM, 32'h0));
        vecs.push_back(mk(E|ZL,   0, 0, 0, EM, 32'h0));

        // clock/reset
        drive(R, 64'h0, 32'h0);
        repeat (2) @(negedge clk);
        check_state("reset", 3'd0, EM, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].ctl, vecs[i].din, vecs[i].bus);
            @(negedge clk);
            check_state($sformatf("v%0d", i), vecs[i].e_cnt, vecs[i].e_flags, vecs[i].e_qz);
        end

        // fill/drain ordering through the scoreboard
        for (int i = 0; i < DEPTH; i++) begin
            d = {32'hC000_0000 + 32'(i), 32'hD000_0000 + 32'(i)};
            exp_q.push_back(d);
            drive(P, d, 0);
            @(negedge clk);
        end
        drive(0, 64'h0, 32'h0);
        @(negedge clk);
        check("fill.count", 32'(zif.count), 32'(DEPTH));
        check("fill.full",  32'(zif.full),  32'h1);
        while (exp_q.size() > 0) begin
            d = exp_q.pop_front();
            drive(E|ZL, 64'h0, 32'h0);
            @(negedge clk);
            check("drain.lo", zif.output_QZ, d[31:0]);
            drive(E|ZH, 64'h0, 32'h0);
            @(negedge clk);
            check("drain.hi", zif.output_QZ, d[63:32]);
            drive(O, 64'h0, 32'h0);
            @(negedge clk);
        end
        drive(0, 64'h0, 32'h0);
        check("drain.empty",    32'(zif.empty),    32'h1);
        check("drain.overflow", 32'(zif.overflow), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
